// File: rtl/fc_feature_streamer.sv
// FC-layer input transmitter: buffers N_FEAT pooled features, streams them
// LANES per beat under fc_en, then hands the FC class decision downstream.

module fc_lane_pick #(
  parameter int N_FEAT = 64,
  parameter int LANES  = 4,
  parameter int DW     = 8,
  parameter int LANE   = 0,
  parameter int WP     = 6,
  parameter int BW     = 4
) (
  input  logic [N_FEAT-1:0][DW-1:0] buf_i,
  input  logic [BW-1:0]             beat_i,
  input  logic                      bypass_i,
  input  logic [DW-1:0]             feat_i,
  output logic [DW-1:0]             lane_o
);
  logic [WP-1:0] idx;

  assign idx = WP'(int'(beat_i) * LANES + LANE);
  // The last feature is still in flight on the load edge, so take it from the input.
  assign lane_o = (bypass_i && (LANE == N_FEAT-1)) ? feat_i : buf_i[idx];
endmodule

module fc_feature_streamer #(
  parameter int N_FEAT  = 64,
  parameter int LANES   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DW-1:0]         feat_in_i,
  input  logic                  feat_valid_i,
  output logic                  feat_ready_o,
  output logic                  fc_en_o,
  output logic [LANES*DW-1:0]   fc_data_o,
  input  logic [1:0]            fc_result_i,
  input  logic                  fc_flag_i,
  output logic [1:0]            class_out_o,
  output logic                  class_valid_o,
  input  logic                  class_ready_i,
  output logic                  err_o
);
  localparam int NB = N_FEAT / LANES;
  localparam int WP = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_FILL, S_STREAM, S_WAIT, S_OUT} state_t;

  state_t                         state_q;
  logic [N_FEAT-1:0][DW-1:0]      feat_buf_q;
  logic [WP-1:0]                  wr_ptr_q;
  logic [BW-1:0]                  beat_q;
  logic [TW-1:0]                  tmo_q;
  logic                           fc_en_q;
  logic [LANES-1:0][DW-1:0]       fc_data_q;
  logic [LANES-1:0][DW-1:0]       beat_data_d;
  logic [1:0]                     class_q;
  logic                           class_vld_q;
  logic                           err_q;
  logic                           accept;
  logic                           last_feat;
  logic                           in_fill;
  logic [BW-1:0]                  sel_beat_d;

  assign in_fill      = (state_q == S_FILL);
  assign feat_ready_o = in_fill && !rst_i;
  assign accept       = feat_valid_i && feat_ready_o;
  assign last_feat    = (wr_ptr_q == WP'(N_FEAT-1));
  // From FILL the next beat is 0; in STREAM it is the one after the current.
  assign sel_beat_d   = in_fill ? '0 : beat_q + BW'(1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_lane_pick #(
      .N_FEAT(N_FEAT), .LANES(LANES), .DW(DW), .LANE(l), .WP(WP), .BW(BW)
    ) u_pick (
      .buf_i    (feat_buf_q),
      .beat_i   (sel_beat_d),
      .bypass_i (in_fill),
      .feat_i   (feat_in_i),
      .lane_o   (beat_data_d[l])
    );
  end

  // Buffer needs no reset: wr_ptr restarts at 0 and every entry is rewritten before use.
  always_ff @(posedge clk_i) begin
    if (accept) feat_buf_q[wr_ptr_q] <= feat_in_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      fc_en_q     <= 1'b0;
      fc_data_q   <= '0;
      class_q     <= '0;
      class_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            if (last_feat) begin
              wr_ptr_q  <= '0;
              beat_q    <= '0;
              fc_en_q   <= 1'b1;
              fc_data_q <= beat_data_d;
              state_q   <= S_STREAM;
            end else begin
              wr_ptr_q <= wr_ptr_q + WP'(1);
            end
          end
        end
        S_STREAM: begin
          if (beat_q == BW'(NB-1)) begin
            tmo_q     <= '0;
            fc_data_q <= '0;
            state_q   <= S_WAIT;
          end else begin
            beat_q    <= beat_q + BW'(1);
            fc_data_q <= beat_data_d;
          end
        end
        S_WAIT: begin
          if (fc_result_i != 2'd2) begin
            class_q     <= fc_result_i;
            class_vld_q <= 1'b1;
            fc_en_q     <= 1'b0;
            state_q     <= S_OUT;
            if (!fc_flag_i) err_q <= 1'b1;
          end else if (tmo_q == TW'(TIMEOUT-1)) begin
            class_q     <= 2'b11;
            class_vld_q <= 1'b1;
            err_q       <= 1'b1;
            fc_en_q     <= 1'b0;
            state_q     <= S_OUT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_OUT: begin
          if (class_ready_i) begin
            class_vld_q <= 1'b0;
            state_q     <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign fc_en_o       = fc_en_q;
  assign fc_data_o     = fc_data_q;
  assign class_out_o   = class_q;
  assign class_valid_o = class_vld_q;
  assign err_o         = err_q;
endmodule

// File: doc/fc_feature_streamer.md
Name: fc_feature_streamer

Overview:
- Transmitter side of the fully-connected layer input interface.
- Collects the flattened feature vector from the upstream pooling stage, one signed 8-bit feature per handshake, into a local buffer.
- Once full, streams the vector to the FC layer as 4 lanes per beat with fc_en held high, then captures the FC class decision.
- Drops fc_en (which clears the FC layer) and presents the class downstream with a valid/ready handshake.

Parameters:
N_FEAT, 64, features per inference; multiple of LANES
LANES, 4, features per FC beat
DW, 8, feature width (signed two's complement)
TIMEOUT, 8, max cycles in WAIT_RES before error

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
feat_in  in  DW  signed feature from pooling stage
feat_valid  in  1  feat_in valid
feat_ready  out  1  buffer accepting features
fc_en  out  1  enable to FC layer; high for whole transaction
fc_data  out  LANES*DW  packed lanes; lane i = bits [i*DW+DW-1 : i*DW]
fc_result  in  2  FC decision: 0 abnormal, 1 normal, 2 not ready
fc_flag  in  1  FC near-done indicator (monitored only)
class_out  out  2  captured class; 2'b11 = timeout error
class_valid  out  1  class_out valid
class_ready  in  1  downstream accepts class
err  out  1  sticky protocol/timeout error; cleared only by rst

Behaviour:
- All sequential logic on posedge clk. rst is sampled synchronously and overrides everything.
- Reset values: state=FILL, wr_ptr=0, beat=0, fc_en=0, fc_data=0, class_out=0, class_valid=0, err=0. feat_ready is 0 while rst is high.
- FILL:
  - feat_ready=1 (combinational from state), fc_en=0.
  - On feat_valid&&feat_ready: buf[wr_ptr]<=feat_in, wr_ptr++.
  - On accepting feature N_FEAT-1 (edge A): wr_ptr<=0, state<=STREAM, fc_en<=1, beat<=0, fc_data<=buf words 0..3 (word 3 taken from feat_in bypass when N_FEAT-1 falls in beat 0; otherwise from buf).
- STREAM:
  - feat_ready=0, fc_en=1.
  - fc_data is registered; beat k carries features k*LANES+i on lane i.
  - Each edge advances beat. FC samples beat k at edge A+k+1.
  - After the edge loading beat N_FEAT/LANES-1 (edge A+15 at defaults) and one more edge, state<=WAIT_RES with tmo=0 and fc_data<=0.
- WAIT_RES:
  - fc_en stays 1 (FC output is only valid while its en is high).
  - If fc_result!=2: class_out<=fc_result, class_valid<=1, fc_en<=0, state<=OUT. If fc_flag is not 1 at that edge, set err.
  - Else tmo++. When tmo reaches TIMEOUT-1: class_out<=2'b11, class_valid<=1, err<=1, fc_en<=0, state<=OUT.
- Nominal latency, defaults: result captured at edge A+17; class_valid first high in the cycle after A+17; fc_en high for exactly 17 cycles.
- OUT:
  - fc_en=0, feat_ready=0.
  - class_valid and class_out hold stable until class_valid&&class_ready.
  - On that edge: class_valid<=0, state<=FILL.
  - No new features are accepted until back in FILL.
- feat_valid gaps in FILL simply stall wr_ptr; no timeout in FILL.
- Reset mid-operation (any state): next cycle is the reset values. fc_en low for one cycle is enough to clear the FC layer. Partial buffer contents are discarded (wr_ptr=0; stale buf data is never streamed).
- Arithmetic: wr_ptr width clog2(N_FEAT), beat width clog2(N_FEAT/LANES), tmo width clog2(TIMEOUT). Feature values pass bit-exact; no arithmetic on data.

Test Plan:
- Features j=0..63 with feat_in = j-32, feat_valid continuous, FC model returns 1 -> fc_en high 17 cycles; beat 0 lanes = {-32,-31,-30,-29}; beat 15 lanes = {28,29,30,31}; class_out=1, class_valid high 18 cycles after the first accept edge +63; err=0.
- feat_valid toggled 1/0 every cycle with FC model returning 0 -> 64 features accepted over 127 cycles; lane order unchanged; class_out=0.
- class_ready held low 10 cycles after class_valid -> class_valid/class_out stable for all 10; feat_ready=0 throughout; FILL re-entered on the cycle after ready.
- FC model holds fc_result=2 forever -> after 8 WAIT_RES cycles class_out=2'b11, class_valid=1, err=1, fc_en=0.
- rst asserted at beat 7 of STREAM -> next cycle fc_en=0, feat_ready=1, class_valid=0; a fresh 64-feature load streams the new data only.
- fc_result=1 presented with fc_flag=0 -> class_out=1 captured, err=1 sticky until rst.
